// File: rtl/rx_frame_parser.sv
// Frame receiver behind the UART receive FIFO: hunts for a two-byte header, checks length and
// an additive checksum, buffers the payload and releases only verified frames on a valid/ready stream.
module rx_frame_parser #(
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 5000,
    parameter logic [7:0] HEAD0   = 8'hEB,
    parameter logic [7:0] HEAD1   = 8'h90
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_i,
    input  logic        p_empty_i,
    output logic        n_rd_o,
    output logic [7:0]  pld_data_o,
    output logic        p_pld_valid_o,
    output logic        p_pld_last_o,
    input  logic        p_pld_ready_i,
    output logic        p_frame_ok_o,
    output logic        p_frame_err_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] err_cnt_o
);

    localparam int             IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             DEPTH     = 1 << IDX_W;
    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  T_LAST    = TW'(TIMEOUT - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] S_HUNT0 = 3'd0;
    localparam logic [2:0] S_HUNT1 = 3'd1;
    localparam logic [2:0] S_LEN   = 3'd2;
    localparam logic [2:0] S_PLD   = 3'd3;
    localparam logic [2:0] S_SUM   = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    localparam logic [1:0] E_LEN     = 2'd1;
    localparam logic [1:0] E_SUM     = 2'd2;
    localparam logic [1:0] E_TIMEOUT = 2'd3;

    logic [2:0]       state_q, state_nxt;
    logic             n_rd_q;
    logic             rd_pend_q;
    logic [7:0]       len_q;
    logic [7:0]       sum_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic [TW-1:0]    tcnt_q;
    logic [7:0]       pld_mem [DEPTH];
    logic             ok_q, err_q;
    logic [1:0]       err_code_q;
    logic [15:0]      frame_cnt_q, err_cnt_q;

    logic             byte_evt;
    logic             timed;
    logic             drain;
    logic             accept;
    logic             last_beat;
    logic             issue;
    logic             set_err;
    logic             frame_ok;
    logic [1:0]       new_code;
    logic [7:0]       idx_ext, rd_idx_ext;

    assign byte_evt = rd_pend_q;
    assign timed    = (state_q == S_LEN) || (state_q == S_PLD) || (state_q == S_SUM);
    assign drain    = (state_q == S_DRAIN);
    assign accept   = drain && p_pld_ready_i;

    always_comb begin
        idx_ext                   = '0;
        idx_ext[IDX_W-1:0]        = idx_q;
        rd_idx_ext                = '0;
        rd_idx_ext[IDX_W-1:0]     = rd_idx_q;
    end

    assign last_beat = (rd_idx_ext == len_q - 8'd1);

    always_comb begin
        state_nxt = state_q;
        set_err   = 1'b0;
        new_code  = err_code_q;
        frame_ok  = 1'b0;
        case (state_q)
            S_HUNT0: begin
                if (byte_evt && data_i == HEAD0) state_nxt = S_HUNT1;
            end
            S_HUNT1: begin
                if (byte_evt) begin
                    if (data_i == HEAD1)      state_nxt = S_LEN;
                    else if (data_i == HEAD0) state_nxt = S_HUNT1;
                    else                      state_nxt = S_HUNT0;
                end
            end
            S_LEN: begin
                if (byte_evt) begin
                    if (data_i == 8'd0 || data_i > MAX_LEN_B) begin
                        set_err   = 1'b1;
                        new_code  = E_LEN;
                        state_nxt = S_HUNT0;
                    end else begin
                        state_nxt = S_PLD;
                    end
                end
            end
            S_PLD: begin
                if (byte_evt && idx_ext == len_q - 8'd1) state_nxt = S_SUM;
            end
            S_SUM: begin
                if (byte_evt) begin
                    if (data_i == sum_q) begin
                        frame_ok  = 1'b1;
                        state_nxt = S_DRAIN;
                    end else begin
                        set_err   = 1'b1;
                        new_code  = E_SUM;
                        state_nxt = S_HUNT0;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && last_beat) state_nxt = S_HUNT0;
            end
            default: state_nxt = S_HUNT0;
        endcase
        // A stalled frame is abandoned once the inter-byte gap reaches TIMEOUT cycles
        if (timed && !byte_evt && tcnt_q == T_LAST) begin
            set_err   = 1'b1;
            new_code  = E_TIMEOUT;
            state_nxt = S_HUNT0;
        end
    end

    // Look at the next state so that no byte gets fetched that would land in DRAIN
    assign issue = n_rd_q && !p_empty_i && (state_nxt != S_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HUNT0;
            n_rd_q      <= 1'b1;
            rd_pend_q   <= 1'b0;
            len_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            rd_idx_q    <= '0;
            tcnt_q      <= '0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q   <= state_nxt;
            n_rd_q    <= !issue;
            rd_pend_q <= !n_rd_q;
            ok_q      <= frame_ok;
            err_q     <= set_err;

            if (timed && !byte_evt && !set_err) tcnt_q <= tcnt_q + 1'b1;
            else                                tcnt_q <= '0;

            if (set_err) begin
                err_code_q <= new_code;
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (frame_ok && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;

            if (state_q == S_LEN && state_nxt == S_PLD) begin
                len_q <= data_i;
                sum_q <= data_i;
                idx_q <= '0;
            end
            if (state_q == S_PLD && byte_evt) begin
                sum_q <= sum_q + data_i;
                idx_q <= idx_q + 1'b1;
            end
            if (frame_ok) rd_idx_q <= '0;
            else if (accept) rd_idx_q <= rd_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_PLD && byte_evt) pld_mem[idx_q] <= data_i;
    end

    assign n_rd_o        = n_rd_q;
    assign p_pld_valid_o = drain;
    assign pld_data_o    = drain ? pld_mem[rd_idx_q] : 8'h00;
    assign p_pld_last_o  = drain && last_beat;
    assign p_frame_ok_o  = ok_q;
    assign p_frame_err_o = err_q;
    assign err_code_o    = err_code_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: doc/rx_frame_parser.md
# rx_frame_parser

Frame-level receiver stage directly downstream of the UART receive core. It pops bytes from the receive core's output FIFO with an active-low read strobe and hunts for a two-byte header. It validates a length byte and an 8-bit additive checksum, and buffers the payload internally. Only checksum-verified payloads are released to the consumer over a valid/ready stream; bad or truncated frames are dropped and counted.

## Interface
Parameters:
- MAX_LEN, 16: maximum payload length in bytes (1..255); sizes the internal payload buffer.
- TIMEOUT, 5000: idle clock cycles allowed between bytes inside a frame.
- HEAD0, 8'hEB: first header byte.
- HEAD1, 8'h90: second header byte.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_i  input  8  byte from the receive FIFO; valid the cycle after n_rd_o is low.
- p_empty_i  input  1  receive FIFO empty.
- n_rd_o  output  1  FIFO read strobe, active low, one-cycle pulses.
- pld_data_o  output  8  payload byte.
- p_pld_valid_o  output  1  pld_data_o valid.
- p_pld_last_o  output  1  final payload byte of the frame.
- p_pld_ready_i  input  1  consumer accepts the byte when high together with valid.
- p_frame_ok_o  output  1  one-cycle pulse per accepted frame.
- p_frame_err_o  output  1  one-cycle pulse per rejected frame.
- err_code_o  output  2  last error: 0 none, 1 bad length, 2 checksum, 3 timeout.
- frame_cnt_o  output  16  accepted frames, saturating at 16'hFFFF.
- err_cnt_o  output  16  rejected frames, saturating at 16'hFFFF.

## Operation
- Reset values:
  - n_rd_o=1.
  - All other outputs 0.
  - State HUNT0.
  - Timeout counter 0.
  - Buffer contents undefined.
- Fetch engine:
  - In states HUNT0, HUNT1, LEN, PLD and SUM, with no read outstanding and p_empty_i=0, drive n_rd_o low for exactly one cycle (registered).
  - Capture data_i on the following cycle; this is the "byte event".
  - At most one read is outstanding, so the peak rate is one byte per 2 cycles.
  - No reads are issued in DRAIN; bytes wait in the FIFO.
- States and transitions (evaluated at a byte event):
  - HUNT0: byte==HEAD0 → HUNT1; otherwise stay.
  - HUNT1: byte==HEAD1 → LEN; byte==HEAD0 → stay; otherwise → HUNT0.
  - LEN: byte of 0 or byte>MAX_LEN → error code 1, → HUNT0. Otherwise store len, sum=byte, idx=0 → PLD.
  - PLD: buf[idx]=byte, sum=sum+byte (mod 256), idx+1; when idx reaches len-1 → SUM.
  - SUM: byte==sum → p_frame_ok_o pulse, frame_cnt+1, rd_idx=0 → DRAIN. Otherwise error code 2 → HUNT0.
  - DRAIN: p_pld_valid_o=1, pld_data_o=buf[rd_idx], p_pld_last_o=(rd_idx==len-1). On valid&&ready, advance rd_idx; on the last accept → HUNT0.
- Timeout:
  - In LEN, PLD and SUM, the counter increments every cycle without a byte event and clears on a byte event.
  - Reaching TIMEOUT → error code 3, → HUNT0.
  - The counter is held at 0 in all other states.
- Error handling:
  - Any error pulses p_frame_err_o, increments err_cnt_o, and loads err_code_o.
  - err_code_o holds until the next error; a successful frame does not clear it.
- Stream rules:
  - While valid and not ready, pld_data_o and p_pld_last_o stay stable.
  - Valid never drops before acceptance.
- Reset mid-operation:
  - Everything returns to reset values in the next cycle.
  - An outstanding read's byte is discarded.
  - A partially drained frame is lost.

## Timing
- Let n_rd_o be low in cycle t.
  - data_i is sampled at the edge ending t+1.
  - The next read may be issued in t+2.
- Checksum byte read in t:
  - p_frame_ok_o and the first p_pld_valid_o appear in cycle t+2.
  - Error pulses for bad length or checksum appear in cycle t+2 in the same way.
- Drain with ready held high:
  - One byte per cycle; len cycles total.
  - After the last acceptance in cycle d, the state is HUNT0 in d+1, and n_rd_o may go low in d+1.
- Timeout with the last byte event in cycle e: p_frame_err_o pulses in cycle e+TIMEOUT+1.
- Counter saturation: at 16'hFFFF, further events pulse the flags but leave the counters unchanged.

## Test plan
- Good frame: feed EB 90 03 11 22 33 69, ready=1 → p_frame_ok_o pulse, payload 11,22,33 on consecutive cycles, last on 33, frame_cnt_o=1.
- Bad checksum: EB 90 03 11 22 33 6A → p_frame_err_o pulse, err_code_o=2, no p_pld_valid_o, err_cnt_o=1.
- Length rejects: EB 90 00, then EB 90 11 (17 > MAX_LEN=16) → two error pulses with err_code_o=1; the parser then accepts EB 90 01 55 56 → payload 55.
- Resync: 00 EB EB 90 01 55 56 → frame accepted, payload 55; the leading 00 and the extra EB are ignored.
- Timeout: EB 90 02 AA, then FIFO empty for 5000 cycles → err_code_o=3 with pulse timing as in Timing; subsequent EB 90 01 07 08 is accepted.
- Backpressure and reset: good 3-byte frame with ready low for 10 cycles mid-drain → data stable, n_rd_o stays high throughout drain. Then rst asserted mid-payload of a following frame → all outputs return to reset values in the next cycle.
